// File: rtl/router_pkg.sv
// Shared router parameters and helpers used by route compute and the switch allocator.
package router_pkg;

  localparam int unsigned IN_PORTS       = 5;
  localparam int unsigned OUT_PORTS      = 5;
  localparam int unsigned OUT_PORT_BITS  = 3;
  localparam int unsigned MAX_REQ_BITS   = 256;
  localparam int unsigned MAX_FIELD_BITS = 8;

  // Index width for n ports; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

  // Requested-port field idx out of a packed vector of bits-wide fields.
  function automatic logic [MAX_FIELD_BITS-1:0] req_field(
    input logic [MAX_REQ_BITS-1:0] v,
    input int unsigned             idx,
    input int unsigned             bits
  );
    logic [MAX_REQ_BITS-1:0] mask;
    mask = (MAX_REQ_BITS'(1) << bits) - MAX_REQ_BITS'(1);
    return MAX_FIELD_BITS'((v >> (idx * bits)) & mask);
  endfunction

endpackage

// File: rtl/rr_switch_allocator_if.sv
// Request/grant bundle between route compute, the allocator and the crossbar.
interface rr_switch_allocator_if #(
  parameter int unsigned IN_PORTS      = router_pkg::IN_PORTS,
  parameter int unsigned OUT_PORTS     = router_pkg::OUT_PORTS,
  parameter int unsigned OUT_PORT_BITS = router_pkg::OUT_PORT_BITS
);

  logic [IN_PORTS-1:0]               requests;
  logic [IN_PORTS*OUT_PORT_BITS-1:0] req_ports;
  logic [IN_PORTS-1:0]               req_tail;
  logic [OUT_PORTS-1:0]              out_ready;
  logic [IN_PORTS-1:0]               grants;
  logic [OUT_PORTS-1:0]              out_locked;

  modport master (
    output requests, req_ports, req_tail, out_ready,
    input  grants, out_locked
  );

  modport slave (
    input  requests, req_ports, req_tail, out_ready,
    output grants, out_locked
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set candidate at or after the pointer, wrapping.
module rr_pick #(
  parameter int unsigned N  = 5,
  parameter int unsigned PW = 3
) (
  input  logic [N-1:0]  cand_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_c_o,
  output logic          valid_c_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_c_o   = '0;
    valid_c_o = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!valid_c_o && cand_i[idx]) begin
        gnt_c_o[idx] = 1'b1;
        valid_c_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_switch_allocator.sv
// Per-output strong round-robin switch allocator with optional wormhole lock.
module rr_switch_allocator #(
  parameter int unsigned IN_PORTS      = router_pkg::IN_PORTS,
  parameter int unsigned OUT_PORTS     = router_pkg::OUT_PORTS,
  parameter int unsigned OUT_PORT_BITS = router_pkg::OUT_PORT_BITS,
  parameter bit          LOCK_EN       = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  rr_switch_allocator_if.slave bus
);

  import router_pkg::*;

  localparam int unsigned PW = idx_w(IN_PORTS);

  logic [PW-1:0]       ptr_q   [OUT_PORTS];
  logic [PW-1:0]       ptr_d   [OUT_PORTS];
  logic [PW-1:0]       owner_q [OUT_PORTS];
  logic [PW-1:0]       owner_d [OUT_PORTS];
  logic [OUT_PORTS-1:0] locked_q, locked_d;
  logic [IN_PORTS-1:0]  grants_q, grants_d;
  logic [IN_PORTS-1:0]  cand     [OUT_PORTS];
  logic [IN_PORTS-1:0]  pick_gnt [OUT_PORTS];
  logic [OUT_PORTS-1:0] pick_vld;

  // Candidate set per output; out-of-range fields match no output.
  always_comb begin
    for (int unsigned o = 0; o < OUT_PORTS; o++) begin
      cand[o] = '0;
      for (int unsigned i = 0; i < IN_PORTS; i++) begin
        cand[o][i] = bus.requests[i] &&
          (req_field(MAX_REQ_BITS'(bus.req_ports), i, OUT_PORT_BITS) == MAX_FIELD_BITS'(o));
      end
    end
  end

  for (genvar g = 0; g < OUT_PORTS; g++) begin : g_pick
    rr_pick #(.N(IN_PORTS), .PW(PW)) u_pick (
      .cand_i    (cand[g]),
      .ptr_i     (ptr_q[g]),
      .gnt_c_o   (pick_gnt[g]),
      .valid_c_o (pick_vld[g])
    );
  end

  // Winner selection, pointer advance and lock bookkeeping.
  always_comb begin
    logic [IN_PORTS-1:0] win;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    grants_d = '0;
    win      = '0;
    for (int unsigned o = 0; o < OUT_PORTS; o++) begin
      win = '0;
      if (locked_q[o]) begin
        if (bus.out_ready[o] && cand[o][owner_q[o]]) win[owner_q[o]] = 1'b1;
      end else if (bus.out_ready[o] && pick_vld[o]) begin
        win = pick_gnt[o];
      end
      for (int unsigned i = 0; i < IN_PORTS; i++) begin
        if (win[i]) begin
          grants_d[i] = 1'b1;
          ptr_d[o]    = (i == IN_PORTS - 1) ? '0 : PW'(i + 1);
          if (bus.req_tail[i]) begin
            locked_d[o] = 1'b0;
          end else if (LOCK_EN) begin
            locked_d[o] = 1'b1;
            owner_d[o]  = PW'(i);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q <= '0;
      locked_q <= '0;
      for (int unsigned o = 0; o < OUT_PORTS; o++) begin
        ptr_q[o]   <= '0;
        owner_q[o] <= '0;
      end
    end else begin
      grants_q <= grants_d;
      locked_q <= locked_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
    end
  end

  assign bus.grants     = grants_q;
  assign bus.out_locked = locked_q;

endmodule

// File: tb/tb_rr_switch_allocator.sv
// Bench for rr_switch_allocator: directed scenarios plus randomized packets, lock and no-lock builds.
module tb_rr_switch_allocator;

  localparam int NI = 5;
  localparam int NO = 5;
  localparam int PB = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [NI-1:0]   req;
  logic [NI-1:0]   tl;
  logic [NI*PB-1:0] rp;
  logic [NO-1:0]   rdy;

  rr_switch_allocator_if #(.IN_PORTS(NI), .OUT_PORTS(NO), .OUT_PORT_BITS(PB)) bl ();
  rr_switch_allocator_if #(.IN_PORTS(NI), .OUT_PORTS(NO), .OUT_PORT_BITS(PB)) bn ();

  assign bl.requests  = req;
  assign bl.req_ports = rp;
  assign bl.req_tail  = tl;
  assign bl.out_ready = rdy;
  assign bn.requests  = req;
  assign bn.req_ports = rp;
  assign bn.req_tail  = tl;
  assign bn.out_ready = rdy;

  rr_switch_allocator #(.IN_PORTS(NI), .OUT_PORTS(NO), .OUT_PORT_BITS(PB), .LOCK_EN(1'b1)) u_lock (
    .clk(clk), .reset(reset), .bus(bl));
  rr_switch_allocator #(.IN_PORTS(NI), .OUT_PORTS(NO), .OUT_PORT_BITS(PB), .LOCK_EN(1'b0)) u_nolock (
    .clk(clk), .reset(reset), .bus(bn));

  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference state: index 0 = wormhole build, 1 = per-flit build.
  int            mptr [2][NO];
  bit            mlk  [2][NO];
  int            mown [2][NO];
  logic [NI-1:0] exp_g [2];
  logic [NO-1:0] exp_l [2];

  // Random traffic state per input.
  bit has [NI];
  int port [NI];
  int left [NI];
  int age [NI];

  function automatic int field(input int i);
    logic [NI*PB-1:0] t;
    t = rp >> (PB * i);
    return int'(t[PB-1:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int o = 0; o < NO; o++) begin
        mptr[m][o] = 0;
        mlk[m][o]  = 1'b0;
        mown[m][o] = 0;
      end
      exp_g[m] = '0;
      exp_l[m] = '0;
    end
  endtask

  // Arbitration rules applied to the inputs currently on the pins.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      logic [NI-1:0] g;
      logic [NO-1:0] l;
      g = '0;
      l = '0;
      for (int o = 0; o < NO; o++) begin
        int w;
        w = -1;
        if (mlk[m][o]) begin
          if (rdy[o] && req[mown[m][o]] && field(mown[m][o]) == o) w = mown[m][o];
        end else if (rdy[o]) begin
          for (int k = 0; k < NI; k++) begin
            int i;
            i = (mptr[m][o] + k) % NI;
            if (w < 0 && req[i] && field(i) == o) w = i;
          end
        end
        if (w >= 0) begin
          g[w] = 1'b1;
          mptr[m][o] = (w + 1) % NI;
          if (m == 0 && !tl[w]) begin
            mlk[m][o]  = 1'b1;
            mown[m][o] = w;
          end else if (tl[w]) begin
            mlk[m][o] = 1'b0;
          end
        end
        l[o] = mlk[m][o];
      end
      exp_g[m] = g;
      exp_l[m] = l;
    end
  endtask

  // One sampled cycle: predict, clock, compare both builds against the model.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("lock.grants",       32'(bl.grants),     32'(exp_g[0]));
    check("lock.out_locked",   32'(bl.out_locked), 32'(exp_l[0]));
    check("nolock.grants",     32'(bn.grants),     32'(exp_g[1]));
    check("nolock.out_locked", 32'(bn.out_locked), 32'(exp_l[1]));
  endtask

  task automatic clr();
    req = '0;
    tl  = '0;
    rp  = '0;
    rdy = '1;
  endtask

  task automatic set_req(input int i, input int p, input bit t);
    req[i] = 1'b1;
    rp[PB*i +: PB] = PB'(p);
    tl[i] = t;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("reset.grants",     32'(bl.grants),     32'd0);
    check("reset.out_locked", 32'(bl.out_locked), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [NI-1:0] cont_exp [4];
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    clr();
    model_reset();
    apply_reset();

    // Contention on output 1 from inputs 0, 2, 4.
    cont_exp[0] = 5'b00001;
    cont_exp[1] = 5'b00100;
    cont_exp[2] = 5'b10000;
    cont_exp[3] = 5'b00001;
    set_req(0, 1, 1'b1);
    set_req(2, 1, 1'b1);
    set_req(4, 1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("contention.grants", 32'(bl.grants), 32'(cont_exp[c]));
    end

    // Wormhole: input 3 owns output 2 until its tail.
    clr();
    apply_reset();
    set_req(3, 2, 1'b0);
    cycle();
    check("worm.head",        32'(bl.grants),     32'b01000);
    check("worm.head_locked", 32'(bl.out_locked), 32'b00100);
    set_req(1, 2, 1'b1);
    cycle();
    check("worm.body",        32'(bl.grants),     32'b01000);
    check("worm.body_locked", 32'(bl.out_locked), 32'b00100);
    set_req(3, 2, 1'b1);
    cycle();
    check("worm.tail",        32'(bl.grants),     32'b01000);
    check("worm.tail_locked", 32'(bl.out_locked), 32'b00000);
    req[3] = 1'b0;
    cycle();
    check("worm.next",        32'(bl.grants),     32'b00010);

    // Backpressure on output 0.
    clr();
    rdy[0] = 1'b0;
    set_req(4, 0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("bp.stalled", 32'(bl.grants), 32'd0);
    end
    rdy[0] = 1'b1;
    cycle();
    check("bp.release", 32'(bl.grants), 32'b10000);

    // All outputs granted in parallel.
    clr();
    for (int i = 0; i < NI; i++) set_req(i, 4 - i, 1'b1);
    cycle();
    check("parallel", 32'(bl.grants), 32'b11111);

    // Out-of-range field is ignored.
    clr();
    set_req(2, 7, 1'b0);
    set_req(0, 1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("invalid.grants", 32'(bl.grants),     32'b00001);
      check("invalid.locked", 32'(bl.out_locked), 32'd0);
    end

    // Reset while output 2 is locked to input 3.
    clr();
    set_req(3, 2, 1'b0);
    cycle();
    check("midrst.locked", 32'(bl.out_locked), 32'b00100);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst.grants_now", 32'(bl.grants),     32'd0);
    check("midrst.locked_now", 32'(bl.out_locked), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    set_req(1, 2, 1'b1);
    cycle();
    check("midrst.first", 32'(bl.grants), 32'b00010);

    // Randomized packet traffic honouring the hold-until-granted handshake.
    clr();
    apply_reset();
    for (int i = 0; i < NI; i++) begin
      has[i] = 1'b0; port[i] = 0; left[i] = 0; age[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        apply_reset();
        for (int i = 0; i < NI; i++) has[i] = 1'b0;
      end
      for (int i = 0; i < NI; i++) begin
        req[i] = has[i];
        rp[PB*i +: PB] = PB'(port[i]);
        tl[i] = (left[i] == 1);
      end
      for (int o = 0; o < NO; o++) rdy[o] = ($urandom % 4) != 0;
      cycle();
      for (int i = 0; i < NI; i++) begin
        if (has[i]) begin
          age[i]++;
          if (exp_g[0][i]) begin
            left[i]--;
            age[i] = 0;
            if (left[i] == 0) has[i] = 1'b0;
          end else if (port[i] >= NO && age[i] > 3) begin
            has[i] = 1'b0;
          end
        end else if ($urandom % 3 == 0) begin
          has[i]  = 1'b1;
          port[i] = int'($urandom % 8);
          left[i] = 1 + int'($urandom % 4);
          age[i]  = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
